// File: rtl/tx_pkt_fifo.sv
// tx_pkt_fifo: store-and-forward transmit packet FIFO.
// Beats from the ACL filter are buffered until the packet's last beat is
// committed. Only committed packets are streamed to the MAC, in commit order,
// with a fixed inter-frame gap. Uncommitted beats can be dropped, and a packet
// too large for the memory is discarded automatically.
module tx_pkt_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 2048,
    parameter int IFG_CYCLES = 12,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tx_wvalid,
    input  logic [DATA_W-1:0] i_tx_wdata,
    input  logic              i_tx_wlast,
    input  logic              i_tx_drop,
    output logic              o_tx_wready,
    output logic [DATA_W-1:0] o_txd_tdata,
    output logic              o_txd_tvalid,
    output logic              o_txd_tlast,
    input  logic              i_txd_tready,
    output logic [ADDR_W:0]   o_pkt_count,
    output logic              o_overflow
);

    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;
    localparam logic [ADDR_W:0]  FILL_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_e;

    // Each entry holds the data beat plus its last-of-packet flag in the MSB.
    logic [DATA_W:0] mem_q [DEPTH];
    logic [DATA_W:0] rd_word;

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] wr_commit_q, wr_commit_d;
    logic [ADDR_W:0] rd_ptr_q;
    logic [ADDR_W:0] fe_ptr_q;
    logic [ADDR_W:0] fill;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            discard_q, discard_d;
    logic            ready_q;
    logic            ovf_q;
    logic            wr_acc, mem_we, commit, ovf_hit;

    state_e          state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic            hs, load, done;
    logic [DATA_W-1:0] tdata_q;
    logic            tvalid_q, tlast_q;

    // rd_ptr marks the first entry of the packet being sent. Space is released
    // only when that packet completes.
    assign fill        = wr_ptr_q - rd_ptr_q;
    assign o_tx_wready = ready_q && !fill[ADDR_W];
    assign wr_acc      = i_tx_wvalid && o_tx_wready;
    assign rd_word     = mem_q[fe_ptr_q[ADDR_W-1:0]];

    assign o_txd_tdata  = tdata_q;
    assign o_txd_tvalid = tvalid_q;
    assign o_txd_tlast  = tlast_q;
    assign o_pkt_count  = cnt_q;
    assign o_overflow   = ovf_q;

    // Write side: store, commit, drop, and auto-discard of a packet that cannot fit.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        discard_d   = discard_q;
        mem_we      = 1'b0;
        commit      = 1'b0;
        ovf_hit     = 1'b0;
        if (i_tx_drop) begin
            wr_ptr_d  = wr_commit_q;
            discard_d = 1'b0;
        end else if (wr_acc) begin
            if (discard_q) begin
                if (i_tx_wlast) begin
                    discard_d = 1'b0;
                end
            end else if (i_tx_wlast) begin
                mem_we      = 1'b1;
                commit      = 1'b1;
                wr_ptr_d    = wr_ptr_q + 1'b1;
                wr_commit_d = wr_ptr_q + 1'b1;
            end else if ((fill == FILL_LAST) && (wr_commit_q == rd_ptr_q)) begin
                // This beat would fill memory with one unfinished packet that can
                // never be sent, so drop the packet now. Ready stays high.
                ovf_hit   = 1'b1;
                wr_ptr_d  = wr_commit_q;
                discard_d = 1'b1;
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
    end

    // Write-side pointer, discard and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            discard_q   <= 1'b0;
            ovf_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            discard_q   <= discard_d;
            ovf_q       <= ovf_hit;
            ready_q     <= 1'b1;
        end
    end

    // Packet storage. Reads are combinational, so the first beat can be
    // loaded in the same cycle the FSM decides to start.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {i_tx_wlast, i_tx_wdata};
        end
    end

    // Read FSM state register and gap counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Read FSM next state. The last gap cycle also serves as the idle decision
    // cycle, so the MAC sees exactly IFG_CYCLES idle cycles between packets.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cnt_q != '0) state_d = S_SEND;
            S_SEND: if (hs && tlast_q) state_d = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
            S_GAP:  if (gap_q == '0) state_d = (cnt_q != '0) ? S_SEND : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read FSM outputs: beat load and packet-done strobes, plus the gap countdown.
    always_comb begin
        hs    = tvalid_q && i_txd_tready;
        load  = ((state_q != S_SEND) && (state_d == S_SEND)) ||
                ((state_q == S_SEND) && hs && !tlast_q);
        done  = (state_q == S_SEND) && hs && tlast_q;
        gap_d = gap_q;
        if (done) begin
            gap_d = GAP_LOAD;
        end else if ((state_q == S_GAP) && (gap_q != '0)) begin
            gap_d = gap_q - 1'b1;
        end
    end

    // Transmit output register, fetch pointer and packet release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            fe_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (load) begin
            tdata_q  <= rd_word[DATA_W-1:0];
            tlast_q  <= rd_word[DATA_W];
            tvalid_q <= 1'b1;
            fe_ptr_q <= fe_ptr_q + 1'b1;
        end else if (done) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            rd_ptr_q <= fe_ptr_q;
        end
    end

    // Committed-packet count. A commit and a completion in the same cycle cancel.
    always_comb begin
        cnt_d = cnt_q;
        case ({commit, done})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Committed-packet count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tx_pkt_fifo.sv
// tb_tx_pkt_fifo: directed bench with a scoreboard queue of expected
// transmit beats and an independent monitor on the transmit stream.
module tb_tx_pkt_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int IFG    = 12;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk;
    logic              rst;
    logic              i_tx_wvalid;
    logic [DATA_W-1:0] i_tx_wdata;
    logic              i_tx_wlast;
    logic              i_tx_drop;
    logic              o_tx_wready;
    logic [DATA_W-1:0] o_txd_tdata;
    logic              o_txd_tvalid;
    logic              o_txd_tlast;
    logic              i_txd_tready;
    logic [ADDR_W:0]   o_pkt_count;
    logic              o_overflow;

    int tests = 0;
    int fails = 0;
    int ovf_seen = 0;

    logic [DATA_W:0] exp_q[$];
    int              gap_q[$];
    logic [7:0]      pkt[$];

    tx_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IFG_CYCLES(IFG)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_tx_wvalid  (i_tx_wvalid),
        .i_tx_wdata   (i_tx_wdata),
        .i_tx_wlast   (i_tx_wlast),
        .i_tx_drop    (i_tx_drop),
        .o_tx_wready  (o_tx_wready),
        .o_txd_tdata  (o_txd_tdata),
        .o_txd_tvalid (o_txd_tvalid),
        .o_txd_tlast  (o_txd_tlast),
        .i_txd_tready (i_txd_tready),
        .o_pkt_count  (o_pkt_count),
        .o_overflow   (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic wr_idle();
        i_tx_wvalid = 1'b0;
        i_tx_wlast  = 1'b0;
        i_tx_drop   = 1'b0;
    endtask

    // Present one beat and hold it until it has been accepted.
    task automatic put_beat(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        i_tx_wvalid = 1'b1;
        i_tx_wdata  = d;
        i_tx_wlast  = l;
        while (!o_tx_wready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) timeout_fail("wready_wait");
        @(posedge clk); #1;
    endtask

    // Write the bytes in pkt as one packet; optionally expect it on the MAC side.
    task automatic write_pkt(input bit expect_tx);
        if (expect_tx) begin
            for (int i = 0; i < pkt.size(); i++)
                exp_q.push_back({(i == pkt.size() - 1), pkt[i]});
        end
        for (int i = 0; i < pkt.size(); i++)
            put_beat(pkt[i], (i == pkt.size() - 1));
        wr_idle();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_txd_tvalid) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) timeout_fail(name);
    endtask

    task automatic wait_data(input logic [7:0] d, input string name);
        int n;
        n = 0;
        while (!(o_txd_tvalid && o_txd_tdata == d) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) timeout_fail(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, o_txd_tvalid, 0);
        check({tag, "_tlast"},  o_txd_tlast, 0);
        check({tag, "_tdata"},  o_txd_tdata, 0);
        check({tag, "_count"},  o_pkt_count, 0);
        check({tag, "_ovf"},    o_overflow, 0);
        check({tag, "_wready"}, o_tx_wready, 0);
    endtask

    // Monitor: scoreboards accepted beats, checks stall stability, measures gaps.
    initial begin
        logic [DATA_W:0]   exp;
        logic [DATA_W+1:0] held;
        bit                hold;
        bit                after_last;
        int                gap_cnt;
        hold = 0;
        after_last = 0;
        gap_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold = 0;
                after_last = 0;
                continue;
            end
            if (o_overflow) ovf_seen++;
            if (hold) check("stall_hold", {o_txd_tvalid, o_txd_tlast, o_txd_tdata}, held);
            hold = 0;
            if (o_txd_tvalid) begin
                if (after_last) begin
                    gap_q.push_back(gap_cnt);
                    after_last = 0;
                end
                if (i_txd_tready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: got data 0x%0h last %0d, expected none",
                                 o_txd_tdata, o_txd_tlast);
                    end else begin
                        exp = exp_q.pop_front();
                        check("tx_beat", {o_txd_tlast, o_txd_tdata}, exp);
                    end
                    if (o_txd_tlast) begin
                        after_last = 1;
                        gap_cnt = 0;
                    end
                end else begin
                    hold = 1;
                    held = {o_txd_tvalid, o_txd_tlast, o_txd_tdata};
                end
            end else if (after_last) begin
                gap_cnt++;
            end
        end
    end

    initial begin
        rst = 1'b0;
        i_txd_tready = 1'b1;
        i_tx_wdata = '0;
        wr_idle();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b1;
        #1;
        check("wready_before_edge", o_tx_wready, 0);
        @(posedge clk); #1;
        check("wready_after_reset", o_tx_wready, 1);

        // 4-beat packet, latency and back-to-back beats
        pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
        write_pkt(1);
        check("lat_n1_tvalid", o_txd_tvalid, 0);
        check("count_after_commit", o_pkt_count, 1);
        @(posedge clk); #1;
        check("lat_n2_tvalid", o_txd_tvalid, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_bubble", o_txd_tvalid, 1);
        end
        @(posedge clk); #1;
        check("tvalid_after_last", o_txd_tvalid, 0);
        check("count_after_tx", o_pkt_count, 0);
        wait_idle("drain_4beat");

        // Drop of uncommitted beats, and drop winning over a last beat
        put_beat(8'hB0, 0);
        put_beat(8'hB1, 0);
        put_beat(8'hB2, 0);
        i_tx_wvalid = 1'b0;
        i_tx_drop = 1'b1;
        @(posedge clk); #1;
        wr_idle();
        check("count_after_drop", o_pkt_count, 0);
        put_beat(8'hC0, 0);
        i_tx_wvalid = 1'b1;
        i_tx_wdata = 8'hC1;
        i_tx_wlast = 1'b1;
        i_tx_drop = 1'b1;
        @(posedge clk); #1;
        wr_idle();
        check("count_drop_vs_last", o_pkt_count, 0);
        repeat (3) @(posedge clk);
        #1;
        check("no_tx_after_drop", o_txd_tvalid, 0);
        pkt = '{8'hA0, 8'hA1};
        write_pkt(1);
        wait_idle("drain_after_drop");

        // Two back-to-back packets separated by the inter-frame gap
        pkt = '{8'h50, 8'h51};
        write_pkt(1);
        pkt = '{8'h60, 8'h61};
        write_pkt(1);
        wait_idle("drain_ifg");
        if (gap_q.size() > 0) check("ifg_cycles", gap_q[$], IFG);
        else timeout_fail("ifg_no_gap_recorded");

        // Back-pressure for 5 cycles mid-packet
        pkt = '{8'h71, 8'h72, 8'h73, 8'h74};
        write_pkt(1);
        wait_data(8'h72, "wait_beat2_stall");
        i_txd_tready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stalled_tvalid", o_txd_tvalid, 1);
        check("stalled_tdata", o_txd_tdata, 8'h72);
        i_txd_tready = 1'b1;
        wait_idle("drain_stall");

        // Oversized packet is discarded with one overflow pulse
        ovf_seen = 0;
        for (int i = 0; i < 20; i++) begin
            check("ovf_wready", o_tx_wready, 1);
            put_beat(8'h80 + 8'(i), (i == 19));
        end
        wr_idle();
        repeat (5) @(posedge clk);
        #1;
        check("ovf_pulses", ovf_seen, 1);
        check("ovf_count", o_pkt_count, 0);
        check("ovf_no_tx", o_txd_tvalid, 0);
        pkt = '{8'h90, 8'h91};
        write_pkt(1);
        wait_idle("drain_after_ovf");

        // Reset during the second beat of a packet
        pkt = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        write_pkt(1);
        wait_data(8'hC2, "wait_beat2_reset");
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("wready_after_midrst", o_tx_wready, 1);
        repeat (30) @(posedge clk);
        #1;
        check("no_tx_after_midrst", o_txd_tvalid, 0);
        check("count_after_midrst", o_pkt_count, 0);
        pkt = '{8'hD0, 8'hD1};
        write_pkt(1);
        wait_idle("drain_after_midrst");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
